// File: rtl/upd78xx_pkg.sv
// Shared types and address-decode helpers for the uPD78xx internal memory block.
package upd78xx_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam int RD_WAIT_W = 3;

  // ROM occupies the bottom of the 64K space; aw == 0 means no ROM at all.
  function automatic logic rom_hit(input logic [15:0] a, input int aw);
    return (aw > 0) && ((a >> aw) == 16'd0);
  endfunction

  // RAM occupies the top 2^aw bytes of the 64K space.
  function automatic logic ram_hit(input logic [15:0] a, input int aw);
    return (a >> (16 - aw)) == (16'hFFFF >> (16 - aw));
  endfunction

endpackage

// File: rtl/upd78xx_sdpram.sv
// Simple dual-port byte RAM: one write port, one registered read port (read-before-write).
module upd78xx_sdpram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge CLK) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/upd78xx_intmem.sv
// Boot ROM + internal RAM + external bus gating for uPD78xx cores, with RAM clear,
// ROM loader/checksum and internal read wait-state insertion.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_CLEAR | sequencer writes RAM_CLR to every RAM byte; core RAM access stalled
//  ST_RUN   | normal operation; core owns RAM writes
//  ST_LOAD  | loader owns ROM; core ROM access stalled
module upd78xx_intmem
  import upd78xx_pkg::*;
#(
  parameter int         ROM_AW  = 12,
  parameter int         RAM_AW  = 7,
  parameter logic [7:0] RAM_CLR = 8'h00,
  parameter int         RD_WAIT = 0
) (
  input  logic        CLK,
  input  logic        RESETB,
  input  logic        INIT_SEL_BOOT,
  input  logic [24:0] INIT_ADDR,
  input  logic [7:0]  INIT_DATA,
  input  logic        INIT_VALID,
  input  logic [15:0] CORE_A,
  input  logic        CORE_RDB,
  input  logic        CORE_WRB,
  input  logic [7:0]  CORE_DB_O,
  input  logic        CORE_DB_OE,
  output logic [7:0]  CORE_DB_I,
  output logic        CORE_WAITB,
  input  logic        EXT_WAITB,
  output logic [15:0] A,
  output logic        A_OE,
  input  logic [7:0]  DB_I,
  output logic [7:0]  DB_O,
  output logic        DB_OE,
  output logic        RDB,
  output logic        WRB,
  output logic        READY,
  output logic        ROM_LOADED,
  output logic [7:0]  ROM_CSUM
);

  if (ROM_AW > 0 && ((1 << ROM_AW) + (1 << RAM_AW)) > 65536) begin : g_overlap_err
    $error("upd78xx_intmem: ROM and RAM windows overlap");
  end

  state_t                state, state_nxt;
  logic [RAM_AW-1:0]     clr_cnt;
  logic [RD_WAIT_W-1:0]  wait_cnt;
  logic                  sel_d, boot_pend, load_any, rd_d;
  logic                  rom_sel, ram_sel, ext_sel, access;
  logic                  sel_rise, sel_fall, init_ok, load_entry, load_exit;
  logic                  ram_we;
  logic [RAM_AW-1:0]     ram_waddr;
  logic [7:0]            ram_wdata, ram_q, rom_q;

  assign rom_sel  = rom_hit(CORE_A, ROM_AW);
  assign ram_sel  = ram_hit(CORE_A, RAM_AW);
  assign ext_sel  = ~rom_sel & ~ram_sel;
  assign access   = ~CORE_RDB | ~CORE_WRB;
  assign sel_rise = INIT_SEL_BOOT & ~sel_d;
  assign sel_fall = ~INIT_SEL_BOOT & sel_d;
  assign init_ok  = (state == ST_LOAD) && INIT_VALID && (ROM_AW > 0)
                    && ((INIT_ADDR >> ROM_AW) == 25'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (&clr_cnt) state_nxt = ST_RUN;
      // boot_pend remembers a rise seen while still clearing
      ST_RUN:   if (INIT_SEL_BOOT && (sel_rise || boot_pend)) state_nxt = ST_LOAD;
      ST_LOAD:  if (!INIT_SEL_BOOT) state_nxt = ST_RUN;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  assign load_entry = (state == ST_RUN) && (state_nxt == ST_LOAD);
  assign load_exit  = (state == ST_LOAD) && (state_nxt == ST_RUN);

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      sel_d      <= 1'b0;
      boot_pend  <= 1'b0;
      load_any   <= 1'b0;
      rd_d       <= 1'b1;
      wait_cnt   <= '0;
      ROM_CSUM   <= 8'h00;
      ROM_LOADED <= 1'b0;
    end else begin
      state <= state_nxt;
      sel_d <= INIT_SEL_BOOT;
      rd_d  <= CORE_RDB;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (sel_rise)      boot_pend <= 1'b1;
      else if (sel_fall) boot_pend <= 1'b0;
      if (load_entry) begin
        ROM_CSUM   <= 8'h00;
        ROM_LOADED <= 1'b0;
        load_any   <= 1'b0;
      end else begin
        if (init_ok) begin
          ROM_CSUM <= ROM_CSUM + INIT_DATA;
          load_any <= 1'b1;
        end
        if (load_exit) ROM_LOADED <= load_any | init_ok;
      end
      if (rd_d && !CORE_RDB && (rom_sel || ram_sel)) wait_cnt <= RD_WAIT_W'(RD_WAIT);
      else if (wait_cnt != '0)                       wait_cnt <= wait_cnt - 1'b1;
    end
  end

  assign ram_we    = (state == ST_CLEAR) || (ram_sel && !CORE_WRB && state == ST_RUN);
  assign ram_waddr = (state == ST_CLEAR) ? clr_cnt : CORE_A[RAM_AW-1:0];
  assign ram_wdata = (state == ST_CLEAR) ? RAM_CLR : CORE_DB_O;

  upd78xx_sdpram #(.AW(RAM_AW), .DW(8)) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (CORE_A[RAM_AW-1:0]),
    .rdata (ram_q)
  );

  if (ROM_AW > 0) begin : g_rom
    upd78xx_sdpram #(.AW(ROM_AW), .DW(8)) u_rom (
      .CLK   (CLK),
      .we    (init_ok),
      .waddr (INIT_ADDR[ROM_AW-1:0]),
      .wdata (INIT_DATA),
      .raddr (CORE_A[ROM_AW-1:0]),
      .rdata (rom_q)
    );
  end else begin : g_no_rom
    assign rom_q = 8'h00;
  end

  always_comb begin
    CORE_DB_I = DB_I;
    if (CORE_DB_OE)                 CORE_DB_I = CORE_DB_O;
    else if (rom_sel && !CORE_RDB)  CORE_DB_I = rom_q;
    else if (ram_sel && !CORE_RDB)  CORE_DB_I = ram_q;
  end

  assign CORE_WAITB = (EXT_WAITB | ~ext_sel)
                    & ~(ram_sel & access & (state == ST_CLEAR))
                    & ~(rom_sel & access & (state == ST_LOAD))
                    & (wait_cnt == '0);

  assign READY = (state != ST_CLEAR);
  assign A_OE  = RESETB & ext_sel;
  assign A     = A_OE ? CORE_A : 16'h0000;
  assign DB_O  = A_OE ? CORE_DB_O : 8'h00;
  assign DB_OE = CORE_DB_OE & A_OE;
  assign RDB   = CORE_RDB | ~A_OE;
  assign WRB   = CORE_WRB | ~A_OE;

endmodule
